// File: rtl/wb_commit_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_unit_pkg
//  Description : Shared definitions for the write-back / commit slice. The
//                width defaults are shared with the integer register file.
//                The source-select enum names the two result producers.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_commit_unit_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  // Register index that is never written (architectural x0)
  localparam int REG_ZERO = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_sel_e;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : Pending-write scoreboard, one bit per architectural
//                register. Decode sets a bit on issue and the commit path
//                clears it when the result is accepted. Bit 0 is never set.
//  Ports       : clk, rstn       - clock, synchronous active-low reset
//                set_en, set_idx - mark a register as pending
//                clr_en, clr_idx - retire a pending write
//                rs1, rs2        - source queries
//                rs1_busy/rs2_busy - combinational pending status
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
  import wb_commit_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [NREG-1:0] c_one = NREG'(1);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_next;

  assign w_set_mask = set_en ? (c_one << set_idx) : '0;
  assign w_clr_mask = clr_en ? (c_one << clr_idx) : '0;

  // Set is applied after clear so a same-index collision leaves the bit set
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == REG_ZERO) begin : g_zero
        assign w_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_next[gi] = (r_pending[gi] & ~w_clr_mask[gi]) | w_set_mask[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_next;
    end
  end

  // Bit 0 is held at zero, so querying x0 reports not busy
  assign rs1_busy = r_pending[rs1];
  assign rs2_busy = r_pending[rs2];

endmodule
`default_nettype wire

// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_unit
//  Description : Write-back stage in front of the integer register file.
//                Round-robin arbitration between ALU and LSU results, a
//                registered single write port, a commit counter and a
//                pending-write scoreboard for decode hazard checks.
//  Ports       : clk, rstn              - clock, synchronous active-low reset
//                alu_* / lsu_*          - result sources (valid/ready)
//                issue_valid, issue_rd  - decode marks a pending destination
//                rs1, rs2, rs*_busy     - decode hazard queries
//                rf_w_en/waddr/wdata    - register file write port (registered)
//                commit_cnt             - accepted results since reset
//  Options     : WB_BYPASS_EN - adds rs*_fwd_valid / rs*_fwd_data forwarding
//                outputs; busy is masked while a forward is available.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_w_en,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef WB_BYPASS_EN
  output logic                  rs1_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data,
`endif
  output logic [CNT_WIDTH-1:0]  commit_cnt
);

  localparam logic [ADDR_WIDTH-1:0] c_reg_zero = ADDR_WIDTH'(REG_ZERO);

  src_sel_e              r_last_grant;
  logic                  w_xfer;
  src_sel_e              w_sel;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_rd_nz;
  logic                  w_sb_rs1_busy;
  logic                  w_sb_rs2_busy;

  // Ready depends only on the valids and the previous grant. With both
  // valid, the source that did not win last time is served.
  assign alu_ready = alu_valid && (!lsu_valid || (r_last_grant == SRC_LSU));
  assign lsu_ready = lsu_valid && (!alu_valid || (r_last_grant == SRC_ALU));

  assign w_xfer  = alu_ready || lsu_ready;
  assign w_sel   = lsu_ready ? SRC_LSU : SRC_ALU;
  assign w_rd    = (w_sel == SRC_LSU) ? lsu_rd   : alu_rd;
  assign w_data  = (w_sel == SRC_LSU) ? lsu_data : alu_data;
  assign w_rd_nz = (w_rd != c_reg_zero);

  // Output register; address/data only reload on a real write so they hold
  // the last written value otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_w_en      <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      commit_cnt   <= '0;
      r_last_grant <= SRC_ALU;
    end else begin
      rf_w_en <= w_xfer && w_rd_nz;
      if (w_xfer) begin
        r_last_grant <= w_sel;
        commit_cnt   <= commit_cnt + CNT_WIDTH'(1);
        if (w_rd_nz) begin
          rf_waddr <= w_rd;
          rf_wdata <= w_data;
        end
      end
    end
  end

  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (issue_valid && (issue_rd != c_reg_zero)),
    .set_idx  (issue_rd),
    .clr_en   (w_xfer && w_rd_nz),
    .clr_idx  (w_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (w_sb_rs1_busy),
    .rs2_busy (w_sb_rs2_busy)
  );

`ifdef WB_BYPASS_EN
  logic w_rs1_hit_now;
  logic w_rs2_hit_now;
  logic w_rs1_hit_reg;
  logic w_rs2_hit_reg;

  // rf_w_en is never set for x0, so the registered match needs no zero check
  assign w_rs1_hit_now = w_xfer && w_rd_nz && (w_rd == rs1);
  assign w_rs2_hit_now = w_xfer && w_rd_nz && (w_rd == rs2);
  assign w_rs1_hit_reg = rf_w_en && (rf_waddr == rs1);
  assign w_rs2_hit_reg = rf_w_en && (rf_waddr == rs2);

  assign rs1_fwd_valid = w_rs1_hit_now || w_rs1_hit_reg;
  assign rs2_fwd_valid = w_rs2_hit_now || w_rs2_hit_reg;
  assign rs1_fwd_data  = w_rs1_hit_now ? w_data : rf_wdata;
  assign rs2_fwd_data  = w_rs2_hit_now ? w_data : rf_wdata;

  assign rs1_busy = w_sb_rs1_busy && !rs1_fwd_valid;
  assign rs2_busy = w_sb_rs2_busy && !rs2_fwd_valid;
`else
  assign rs1_busy = w_sb_rs1_busy;
  assign rs2_busy = w_sb_rs2_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_commit_unit
//  Description : Self-checking bench for wb_commit_unit. A vector table
//                drives the arbiter; expected register-file writes are queued
//                when a vector is applied and popped one cycle later. Hand
//                sequences cover the scoreboard, reset and forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_w_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, commit_cnt;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  wb_commit_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_w_en     (rf_w_en),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
`ifdef WB_BYPASS_EN
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs2_fwd_data  (rs2_fwd_data),
`endif
    .commit_cnt  (commit_cnt)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ear;
    logic        elr;
  } vec_t;

  typedef struct {
    logic        en;
    logic        chk;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[12];
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                              logic lv, logic [4:0] lrd, logic [31:0] ldat,
                              logic ear, logic elr);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.ear = ear; v.elr = elr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue: no expected write available");
    end else begin
      e = q.pop_front();
      check("rf_w_en", rf_w_en, e.en);
      if (e.chk) begin
        check("rf_waddr", rf_waddr, e.addr);
        check("rf_wdata", rf_wdata, e.data);
      end
    end
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    logic [4:0]  last_a;
    logic [31:0] last_d;
    exp_t        e;

    // Expected ready values are derived by hand from last_grant=ALU at reset
    tbl[0]  = mk(1, 5'd5,  32'h1234, 0, 5'd0,  32'h0,  1, 0);
    tbl[1]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  0, 0);
    tbl[2]  = mk(1, 5'd3,  32'hA,    1, 5'd4,  32'hB,  0, 1);
    tbl[3]  = mk(1, 5'd3,  32'hA,    1, 5'd4,  32'hB,  1, 0);
    tbl[4]  = mk(0, 5'd0,  32'h0,    1, 5'd8,  32'h88, 0, 1);
    tbl[5]  = mk(0, 5'd0,  32'h0,    1, 5'd9,  32'h99, 0, 1);
    tbl[6]  = mk(1, 5'd10, 32'hAA,   1, 5'd11, 32'hBB, 1, 0);
    tbl[7]  = mk(0, 5'd0,  32'h0,    1, 5'd11, 32'hBB, 0, 1);
    tbl[8]  = mk(1, 5'd0,  32'hFFFF, 0, 5'd0,  32'h0,  1, 0);
    tbl[9]  = mk(1, 5'd12, 32'hC,    1, 5'd13, 32'hD,  0, 1);
    tbl[10] = mk(1, 5'd12, 32'hC,    1, 5'd14, 32'hE,  1, 0);
    tbl[11] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  0, 0);

    rstn = 0; idle();
    alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_data = 0;
    issue_rd = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;

    exp_cnt = 0; last_a = 0; last_d = 0;
    e.en = 0; e.chk = 1; e.addr = 0; e.data = 0;
    q.push_back(e);

    // ---------------- table-driven arbitration / write-port vectors
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ldat;
      @(negedge clk);
      check("alu_ready", alu_ready, tbl[i].ear);
      check("lsu_ready", lsu_ready, tbl[i].elr);
      pop_check();
      check("commit_cnt", commit_cnt, exp_cnt);
      if (tbl[i].ear || tbl[i].elr) begin
        e.addr = tbl[i].ear ? tbl[i].ard  : tbl[i].lrd;
        e.data = tbl[i].ear ? tbl[i].adat : tbl[i].ldat;
        e.en   = (e.addr != 0);
        e.chk  = e.en;
        if (e.en) begin last_a = e.addr; last_d = e.data; end
        exp_cnt++;
      end else begin
        e.en = 0; e.chk = 1; e.addr = last_a; e.data = last_d;
      end
      q.push_back(e);
    end
    @(posedge clk); #1 idle();
    @(negedge clk);
    pop_check();
    check("commit_cnt_end", commit_cnt, exp_cnt);

    // ---------------- scoreboard set by issue, cleared by lsu transfer
    @(posedge clk); #1 issue_valid = 1; issue_rd = 7; rs1 = 7;
    @(negedge clk);
    check("rs1_busy_before_set", rs1_busy, 0);
    @(posedge clk); #1 issue_valid = 0;
    @(negedge clk);
    check("rs1_busy_set", rs1_busy, 1);
    @(posedge clk); #1 lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("rs1_busy_xfer_fwd", rs1_busy, 0);
`else
    check("rs1_busy_xfer", rs1_busy, 1);
`endif
    @(posedge clk); #1 lsu_valid = 0;
    exp_cnt++;
    @(negedge clk);
    check("rs1_busy_cleared", rs1_busy, 0);
    check("rf_w_en_rd7", rf_w_en, 1);
    check("rf_waddr_rd7", rf_waddr, 7);
    check("rf_wdata_rd7", rf_wdata, 32'h77);
    check("commit_cnt_rd7", commit_cnt, exp_cnt);

    // ---------------- issue to x0 never marks busy
    @(posedge clk); #1 issue_valid = 1; issue_rd = 0; rs1 = 0;
    @(posedge clk); #1 issue_valid = 0;
    @(negedge clk);
    check("rs1_busy_x0", rs1_busy, 0);

    // ---------------- reset mid-stream drops in-flight transfer
    @(posedge clk); #1 issue_valid = 1; issue_rd = 9; rs1 = 9;
    @(posedge clk); #1 issue_valid = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h9; rstn = 0;
    @(negedge clk);
    check("alu_ready_pre_rst", alu_ready, 1);
`ifndef WB_BYPASS_EN
    check("rs1_busy_pre_rst", rs1_busy, 1);
`endif
    @(posedge clk); #1 alu_valid = 0; rstn = 1;
    @(negedge clk);
    check("rf_w_en_rst", rf_w_en, 0);
    check("rs1_busy_rst", rs1_busy, 0);
    check("commit_cnt_rst", commit_cnt, 0);
    check("rf_waddr_rst", rf_waddr, 0);

    // ---------------- last_grant back to ALU after reset: LSU wins first
    @(posedge clk); #1;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    @(negedge clk);
    check("lsu_ready_post_rst", lsu_ready, 1);
    check("alu_ready_post_rst", alu_ready, 0);
    @(posedge clk); #1 lsu_valid = 0;
    @(negedge clk);
    check("alu_ready_hold", alu_ready, 1);
    check("rf_waddr_lsu2", rf_waddr, 2);
    check("rf_wdata_lsu2", rf_wdata, 32'h22);
    @(posedge clk); #1 idle();
    @(negedge clk);
    check("rf_waddr_alu1", rf_waddr, 1);
    check("rf_wdata_alu1", rf_wdata, 32'h11);
    check("commit_cnt_post_rst", commit_cnt, 2);

`ifdef WB_BYPASS_EN
    // ---------------- forwarding from transfer, then from output register
    @(posedge clk); #1 issue_valid = 1; issue_rd = 6; rs2 = 6;
    @(posedge clk); #1 issue_valid = 0; alu_valid = 1; alu_rd = 6; alu_data = 32'h55;
    @(negedge clk);
    check("rs2_fwd_valid_now", rs2_fwd_valid, 1);
    check("rs2_fwd_data_now", rs2_fwd_data, 32'h55);
    check("rs2_busy_now", rs2_busy, 0);
    @(posedge clk); #1 alu_valid = 0;
    @(negedge clk);
    check("rs2_fwd_valid_reg", rs2_fwd_valid, 1);
    check("rs2_fwd_data_reg", rs2_fwd_data, 32'h55);
    check("rs2_busy_reg", rs2_busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rs2_fwd_valid_off", rs2_fwd_valid, 0);
`endif

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Write-back stage directly upstream of the integer register file.
- Accepts results from the ALU path and the load/store path over valid/ready, and arbitrates between them.
- Drives the register file's single write port (w_en, waddr, wdata) from a registered output stage.
- Keeps a pending-write scoreboard that decode uses for RAW/WAW stalls.

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH architectural registers.
- DATA_WIDTH, 32, register data width.
- CNT_WIDTH, 32, width of the commit counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  load result valid
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  ADDR_WIDTH  load destination register
- lsu_data  in  DATA_WIDTH  load result
- issue_valid  in  1  decode issues an instruction this cycle
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction
- rs1  in  ADDR_WIDTH  decode source 1 query
- rs2  in  ADDR_WIDTH  decode source 2 query
- rs1_busy  out  1  rs1 has a pending write
- rs2_busy  out  1  rs2 has a pending write
- rf_w_en  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- commit_cnt  out  CNT_WIDTH  number of accepted results since reset

Behaviour:
- Reset: clk rising edge with rstn=0 clears the following.
  - rf_w_en=0, rf_waddr=0, rf_wdata=0, commit_cnt=0.
  - All scoreboard bits cleared; last_grant=ALU.
  - Any in-flight result is dropped.
- Handshake: a transfer on a source occurs when valid && ready on that source. ready is combinational from both valids and last_grant only, never from data.
- Arbitration, round-robin:
  - Only one source valid: that source gets ready=1.
  - Both valid: the source not equal to last_grant wins; the loser sees ready=0 and must hold valid, rd and data stable.
  - last_grant updates only on a transfer.
- Output stage: registered, latency 1. Transfer in cycle N gives rf_w_en=1 with the winner's rd/data during cycle N+1. The register file samples it at the end of N+1, so the value is readable in cycle N+2.
- rd==0: the transfer is accepted and counted, but rf_w_en stays 0 (x0 is never written).
- No transfer in a cycle: rf_w_en=0 next cycle; rf_waddr/rf_wdata hold their old values.
- Scoreboard: one bit per register; bit 0 is hard-wired 0.
  - issue_valid with issue_rd!=0 sets bit[issue_rd].
  - A transfer with rd!=0 clears bit[rd] at the same edge as the output register load.
  - Same-cycle set and clear on the same index: set wins. This only arises from a protocol violation, since decode must not issue to a busy rd.
- rs1_busy/rs2_busy: combinational, equal to bit[rs]. rs==0 gives 0.
- commit_cnt: +1 per transfer, wraps modulo 2**CNT_WIDTH.
- No backpressure from the register file; the unit never stalls when only one source is valid.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, add outputs rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data (1 / DATA_WIDTH bits each).
  - fwd_valid=1 when a transfer occurs this cycle with rd==rs and rs!=0; fwd_data is the winner's data, combinational.
  - Otherwise fwd_valid=1 when rf_w_en && rf_waddr==rs; fwd_data=rf_wdata.
  - The transfer-this-cycle match takes priority.
  - rsN_busy is masked to 0 whenever rsN_fwd_valid=1.
- When undefined, these ports do not exist and busy is pure scoreboard.

Decomposition:
- Shared package holds:
  - ADDR_WIDTH/DATA_WIDTH defaults shared with the register file.
  - A source-select enum {SRC_ALU, SRC_LSU}.
  - Constant REG_ZERO=0.
- One natural sub-module: wb_scoreboard, which owns the pending bits and set/clear/query logic. The arbiter and output register stay in the top level.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle:
  - Next cycle rf_w_en=1, rf_waddr=5, rf_wdata=0x1234.
  - The cycle after, rf_w_en=0; commit_cnt=1.
- Both valid for 2 cycles (alu rd=3/0xA, lsu rd=4/0xB, sources holding until accepted):
  - Cycle 0 grants LSU (last_grant=ALU after reset); cycle 1 grants ALU.
  - Writes appear in order rd4=0xB then rd3=0xA; commit_cnt=2.
- issue_valid, issue_rd=7 → rs1=7 gives rs1_busy=1 the next cycle. lsu transfer rd=7 → rs1_busy=0 after that edge.
- alu transfer rd=0, data=0xFFFF → rf_w_en stays 0, commit_cnt increments, rs1=0 gives busy=0.
- rstn=0 mid-stream while bit[9] is set and a transfer is in flight → rf_w_en=0, rs1=9 gives busy=0, commit_cnt=0 the next cycle.
- WB_BYPASS_EN defined, alu transfer rd=6/0x55 with rs2=6 → same cycle rs2_fwd_valid=1, data=0x55, rs2_busy=0; the following cycle still forwarded from the output register.
